sliscp_inv_step: RTL and testbench
==================================

# sliscp_inv_step

Inverse of one sLiSCP-light permutation step over a 4×WIDTH-bit state. Given a post-step state and the same step constants, it recovers the pre-step state. Both Simeck boxes are inverted by an iterative inverse-round datapath with a start/done handshake. It sits beside the forward step in the permutation core and serves decryption-side state rewinding and forward/inverse round-trip checking.

## Interface
- WIDTH, 64, bits per state word (even); half-word H = WIDTH/2
- ROUNDS, 8, Simeck rounds per box; 1..8
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin inversion; accepted only in IDLE or DONE
- sin  in  4*WIDTH  post-step state {t0,t1,t2,t3}, t0 in MSBs; sampled on accepted start
- rc0  in  8  round constants of the t0/s1 box; sampled on accepted start
- rc1  in  8  round constants of the t2/s3 box; sampled on accepted start
- sc0  in  8  step constant for s0; sampled on accepted start
- sc1  in  8  step constant for s2; sampled on accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, sout valid
- sout  out  4*WIDTH  recovered state {s0,s1,s2,s3}, registered

## Operation
- Step constants: scX_step = {(WIDTH-8) ones, scX}. Round constant c_i(rc) = {(H-1) ones, rc[i]}.
- Half split: word = {x, y}, with x in the upper H bits. f(x) = (x & rotl(x,5)) ^ rotl(x,1).
- Forward round i (definition only): x' = f(x) ^ y ^ c_i; y' = x. The forward box applies i = 0..ROUNDS-1.
- Inverse round i: x = y'; y = x' ^ f(y') ^ c_i. Rounds are applied for i = ROUNDS-1 down to 0.
- Outputs:
  - s1 = SB⁻¹(t0, rc0)
  - s3 = SB⁻¹(t2, rc1)
  - s2 = t1 ^ t2 ^ sc1_step
  - s0 = t3 ^ t0 ^ sc0_step
- s0 and s2 are computed at load. The registered copies of s0 and s2 are held until the result is written.
- Both boxes run in lockstep on one shared round counter.
- FSM:
  - IDLE: on start, load box registers from t0 and t2, latch rc0/rc1, set ctr = ROUNDS-1, go to RUN.
  - RUN: apply one inverse round per box using rc[ctr]. If ctr == 0, go to DONE; otherwise decrement ctr.
  - DONE: write sout, pulse done, return to IDLE. A start in DONE is accepted and behaves exactly as from IDLE.
- start during RUN is ignored; the inputs are not re-sampled.
- sout holds its value until the next DONE.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, sout = 0, ctr = 0.
- Start accepted at edge N: RUN occupies cycles N+1 .. N+ROUNDS.
- done = 1 and the new sout are visible in cycle N+ROUNDS+1. Latency is ROUNDS+1 cycles: 9 with defaults.
- Back-to-back: start asserted during the done cycle yields the next done ROUNDS+1 cycles later.
- rst during RUN aborts at the next edge: all outputs return to their reset values and no done is issued.
- sin, rc and sc may change freely after the accepting edge.

## Configuration
- SLISCP_INV_UNROLL2_EN defined: two inverse rounds per RUN cycle (rc[ctr], then rc[ctr-1]); ctr decrements by 2. With an odd ROUNDS, the last cycle applies a single round.
  - RUN length is ceil(ROUNDS/2) cycles.
  - Latency is ceil(ROUNDS/2)+1 cycles: 5 with defaults.
- Undefined: one round per cycle, as above.
- Results are bit-identical in both builds.

## Test plan
- Reset: hold rst 2 cycles -> sout = 0, busy = 0, done = 0. Then assert rst in the 3rd RUN cycle -> no done, outputs return to 0 the next cycle.
- ROUNDS=1, sin = 0, rc0 = rc1 = 0x00, sc0 = sc1 = 0x00 -> after 2 cycles:
  - s1 = s3 = 64'h00000000_FFFFFFFE
  - s0 = s2 = 64'hFFFFFFFF_FFFFFF00
- Step-constant path: t1 = t2 = 0, t3 = t0 = 0, sc1 = 0x5A, sc0 = 0xA5 -> s2 = 64'hFFFFFFFF_FFFFFF5A, s0 = 64'hFFFFFFFF_FFFFFFA5.
- Round trip, defaults: 1000 random states and constants through the forward step, then this block -> sout equals the original state. done arrives exactly 9 cycles after start.
- Handshake: start pulsed again in RUN cycles 2 and 5 -> ignored, a single done. start held high across done -> a new operation begins, with the second done 9 cycles later.
- Same round-trip run with SLISCP_INV_UNROLL2_EN defined -> identical sout, latency 5; with ROUNDS=7, latency 5.

Source files
------------

// File: rtl/sliscp_inv_step.sv
// sliscp_inv_step: inverse of one sLiSCP-light step, recovering the pre-step state
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start            begin an inversion (accepted in IDLE or DONE)
//   sin              post-step state {t0,t1,t2,t3}, t0 in MSBs
//   rc0, rc1         round constants of the t0/s1 and t2/s3 boxes
//   sc0, sc1         step constants for s0 and s2
//   busy             high while inverse rounds run
//   done             one-cycle pulse when sout holds a new result
//   sout             recovered state {s0,s1,s2,s3}, registered
// Build option: SLISCP_INV_UNROLL2_EN applies two inverse rounds per RUN cycle.
module sliscp_inv_step #(
    parameter int WIDTH  = 64,
    parameter int ROUNDS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4*WIDTH-1:0] sin,
    input  logic [7:0]         rc0,
    input  logic [7:0]         rc1,
    input  logic [7:0]         sc0,
    input  logic [7:0]         sc1,
    output logic               busy,
    output logic               done,
    output logic [4*WIDTH-1:0] sout
);
    localparam int H = WIDTH / 2;
    localparam logic [2:0] CTR_INIT = 3'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       ctr, ctr_nx;
    logic [WIDTH-1:0] b0, b1, s0_r, s2_r;
    logic [WIDTH-1:0] r0, r1, b0_nx, b1_nx;
    logic [7:0]       rc0_r, rc1_r;
    logic             accept, last;

    logic [WIDTH-1:0] t0, t1, t2, t3;
    assign {t0, t1, t2, t3} = sin;

    function automatic logic [H-1:0] rotl(input logic [H-1:0] x, input int n);
        return (x << n) | (x >> (H - n));
    endfunction

    function automatic logic [H-1:0] f(input logic [H-1:0] x);
        return (x & rotl(x, 5)) ^ rotl(x, 1);
    endfunction

    // {x',y'} -> {y', x' ^ f(y') ^ c}
    function automatic logic [WIDTH-1:0] inv_rnd(input logic [WIDTH-1:0] w, input logic c);
        logic [H-1:0] xp, yp;
        xp = w[WIDTH-1:H];
        yp = w[H-1:0];
        return {yp, xp ^ f(yp) ^ {{(H-1){1'b1}}, c}};
    endfunction

    assign r0 = inv_rnd(b0, rc0_r[ctr]);
    assign r1 = inv_rnd(b1, rc1_r[ctr]);

`ifdef SLISCP_INV_UNROLL2_EN
    logic [2:0] ctr_m1;
    assign ctr_m1 = ctr - 3'd1;
    // ctr == 0 only happens on the final cycle of an odd round count
    assign b0_nx  = (ctr == 3'd0) ? r0 : inv_rnd(r0, rc0_r[ctr_m1]);
    assign b1_nx  = (ctr == 3'd0) ? r1 : inv_rnd(r1, rc1_r[ctr_m1]);
    assign last   = (ctr <= 3'd1);
    assign ctr_nx = ctr - 3'd2;
`else
    assign b0_nx  = r0;
    assign b1_nx  = r1;
    assign last   = (ctr == 3'd0);
    assign ctr_nx = ctr - 3'd1;
`endif

    assign accept = start && (state != RUN);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        if (accept)
            state_nx = RUN;
        else if (state == RUN && last)
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
        busy = (state == RUN);
        done = (state == DONE);
    end

    // sout is written on the last RUN edge so it is visible together with done
    always_ff @(posedge clk) begin
        if (rst) begin
            b0    <= '0;
            b1    <= '0;
            s0_r  <= '0;
            s2_r  <= '0;
            rc0_r <= '0;
            rc1_r <= '0;
            ctr   <= '0;
            sout  <= '0;
        end else if (accept) begin
            b0    <= t0;
            b1    <= t2;
            s0_r  <= t3 ^ t0 ^ {{(WIDTH-8){1'b1}}, sc0};
            s2_r  <= t1 ^ t2 ^ {{(WIDTH-8){1'b1}}, sc1};
            rc0_r <= rc0;
            rc1_r <= rc1;
            ctr   <= CTR_INIT;
        end else if (state == RUN) begin
            b0  <= b0_nx;
            b1  <= b1_nx;
            ctr <= last ? 3'd0 : ctr_nx;
            if (last)
                sout <= {s0_r, b0_nx, s2_r, b1_nx};
        end
    end
endmodule

// File: tb/tb_sliscp_inv_step.sv
// tb_sliscp_inv_step: random forward/inverse round-trip bench for sliscp_inv_step
module tb_sliscp_inv_step;
`ifdef SLISCP_INV_UNROLL2_EN
    localparam int LAT  = 5;
    localparam int LAT7 = 5;
`else
    localparam int LAT  = 9;
    localparam int LAT7 = 8;
`endif
    localparam int LAT1 = 2;

    logic         clk = 1'b0;
    logic         rst, start, start1, start7;
    logic [255:0] sin;
    logic [7:0]   rc0, rc1, sc0, sc1;
    logic         busy, done, busy1, done1, busy7, done7;
    logic [255:0] sout, sout1, sout7;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    sliscp_inv_step #(.WIDTH(64), .ROUNDS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .rc0(rc0), .rc1(rc1),
        .sc0(sc0), .sc1(sc1), .busy(busy), .done(done), .sout(sout));
    sliscp_inv_step #(.WIDTH(64), .ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sin(sin), .rc0(rc0), .rc1(rc1),
        .sc0(sc0), .sc1(sc1), .busy(busy1), .done(done1), .sout(sout1));
    sliscp_inv_step #(.WIDTH(64), .ROUNDS(7)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .sin(sin), .rc0(rc0), .rc1(rc1),
        .sc0(sc0), .sc1(sc1), .busy(busy7), .done(done7), .sout(sout7));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] fx(input logic [31:0] x);
        return (x & rl(x, 5)) ^ rl(x, 1);
    endfunction

    // forward Simeck box, rounds 0..r-1
    function automatic logic [63:0] sb(input logic [63:0] w, input logic [7:0] rc, input int r);
        logic [31:0] x, y, t;
        x = w[63:32];
        y = w[31:0];
        for (int i = 0; i < r; i++) begin
            t = fx(x) ^ y ^ {31'h7fffffff, rc[i]};
            y = x;
            x = t;
        end
        return {x, y};
    endfunction

    // forward step; k = {rc0, rc1, sc0, sc1}, s = {s0,s1,s2,s3}, result {t0,t1,t2,t3}
    function automatic logic [255:0] fwd(input logic [255:0] s, input logic [31:0] k, input int r);
        logic [63:0] t0, t2;
        t0 = sb(s[191:128], k[31:24], r);
        t2 = sb(s[63:0], k[23:16], r);
        return {t0, s[127:64] ^ t2 ^ {56'hffffffffffffff, k[7:0]}, t2,
                s[255:192] ^ t0 ^ {56'hffffffffffffff, k[15:8]}};
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic dn(input int w);
        return (w == 0) ? done : (w == 1) ? done1 : done7;
    endfunction

    task automatic drive(input logic [255:0] s, input logic [31:0] k);
        sin = s;
        {rc0, rc1, sc0, sc1} = k;
    endtask

    // one operation on DUT w; inputs are scrambled right after the accepting edge
    task automatic run(input int w, input logic [255:0] st, input logic [31:0] k,
                       output logic [255:0] res, output int lat);
        drive(st, k);
        start  = (w == 0);
        start1 = (w == 1);
        start7 = (w == 7);
        @(posedge clk); #1;
        start = 0; start1 = 0; start7 = 0;
        drive(rnd256(), $urandom);
        lat = 1;
        while (!dn(w) && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        res = (w == 0) ? sout : (w == 1) ? sout1 : sout7;
    endtask

    initial begin
        logic [255:0] a, b, res, r1, r2;
        logic [31:0]  ka, kb;
        int lat, k, nd, dk, d1k, d2k, p2;
        rst = 1; start = 0; start1 = 0; start7 = 0;
        drive('0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_sout", sout, '0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 0;
        @(posedge clk); #1;

        run(1, '0, '0, res, lat);
        check("r1_zero_sout", res, {64'hFFFFFFFF_FFFFFF00, 64'h00000000_FFFFFFFE,
                                    64'hFFFFFFFF_FFFFFF00, 64'h00000000_FFFFFFFE});
        check("r1_lat", lat, LAT1);

        run(0, '0, {$urandom_range(0, 65535), 8'hA5, 8'h5A}, res, lat);
        check("sc_s0", res[255:192], 64'hFFFFFFFF_FFFFFFA5);
        check("sc_s2", res[127:64], 64'hFFFFFFFF_FFFFFF5A);

        for (int i = 0; i < 1000; i++) begin
            a = rnd256(); ka = $urandom;
            run(0, fwd(a, ka, 8), ka, res, lat);
            check("rt8_sout", res, a);
            check("rt8_lat", lat, LAT);
        end

        for (int i = 0; i < 30; i++) begin
            a = rnd256(); ka = $urandom;
            run(7, fwd(a, ka, 7), ka, res, lat);
            check("rt7_sout", res, a);
            check("rt7_lat", lat, LAT7);
        end

        // start re-pulsed during RUN must be ignored
        p2 = (LAT - 1 >= 5) ? 5 : LAT - 1;
        a = rnd256(); ka = $urandom;
        drive(fwd(a, ka, 8), ka);
        start = 1;
        k = 0; nd = 0; dk = 0; res = '0;
        while (k < 2 * LAT + 4) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) check("hs_busy", busy, 1);
            if (done) begin
                nd++;
                if (dk == 0) begin dk = k; res = sout; end
            end
            start = (k == 2 || k == p2);
            drive(rnd256(), $urandom);
        end
        start = 0;
        check("hs_ndone", nd, 1);
        check("hs_lat", dk, LAT);
        check("hs_sout", res, a);

        // start held across done: second operation accepted in the done cycle
        a = rnd256(); ka = $urandom;
        b = rnd256(); kb = $urandom;
        drive(fwd(a, ka, 8), ka);
        start = 1;
        k = 0; d1k = 0; d2k = 0; r1 = '0; r2 = '0;
        while (k < 3 * LAT && d2k == 0) begin
            @(posedge clk); #1;
            k++;
            if (done) begin
                if (d1k == 0) begin
                    d1k = k; r1 = sout;
                    drive(fwd(b, kb, 8), kb);
                end else begin
                    d2k = k; r2 = sout;
                end
            end else if (d1k != 0) start = 0;
        end
        start = 0;
        check("b2b_lat1", d1k, LAT);
        check("b2b_sout1", r1, a);
        check("b2b_lat2", d2k, 2 * LAT);
        check("b2b_sout2", r2, b);

        // reset in the third RUN cycle aborts the operation
        a = rnd256(); ka = $urandom;
        drive(fwd(a, ka, 8), ka);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sout", sout, '0);
        rst = 0;
        nd = 0;
        repeat (2 * LAT) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_nodone", nd, 0);

        a = rnd256(); ka = $urandom;
        run(0, fwd(a, ka, 8), ka, res, lat);
        check("post_rst_sout", res, a);
        check("post_rst_lat", lat, LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
